// File: rtl/sfm_minmax_ctrl.sv
// Sequencer for one global min/max tracker in the softmax datapath.
// Clears (and optionally preloads) the tracker, streams len vectors into it,
// lets the reduction tree drain and returns the final value with a done pulse.
// The element width is a plain parameter (16 = FP16ALT), and the mode is a
// single bit: 0 = MIN, 1 = MAX.
module sfm_minmax_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned VECT_WIDTH = 1,
  parameter int unsigned NUM_REGS   = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        start_i,
  input  logic [CNT_WIDTH-1:0]        len_i,
  input  logic                        mode_i,
  input  logic                        init_en_i,
  input  logic [WIDTH-1:0]            init_val_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [VECT_WIDTH-1:0]       in_strb_i,
  input  logic [VECT_WIDTH*WIDTH-1:0] in_vect_i,
  output logic                        mm_clear_o,
  output logic                        mm_enable_o,
  output logic                        mm_valid_o,
  output logic                        mm_ready_o,
  output logic                        mm_load_en_o,
  output logic                        mm_operation_o,
  output logic [VECT_WIDTH-1:0]       mm_strb_o,
  output logic [VECT_WIDTH*WIDTH-1:0] mm_vect_o,
  output logic [WIDTH-1:0]            mm_load_o,
  input  logic                        mm_ready_i,
  input  logic [WIDTH-1:0]            mm_cur_minmax_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [WIDTH-1:0]            result_o
);

  // state  | meaning
  // IDLE   | waiting for start_i
  // CLEAR  | tracker reset to the identity of the selected mode
  // LOAD   | tracker preloaded with the partial result of an earlier chunk
  // STREAM | vectors pass through until len handshakes are counted
  // DRAIN  | NUM_REGS cycles for the reduction tree to empty
  // DONE   | final value captured into result_o, done pulse

  localparam logic MODE_MAX = 1'b1;
  localparam int unsigned DW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'((NUM_REGS > 0) ? NUM_REGS - 1 : 0);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, STREAM, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, cnt_q;
  logic [DW-1:0]        drain_q;
  logic                 mode_q, init_en_q;
  logic [WIDTH-1:0]     init_val_q, result_q;
  logic                 busy_q, clear_q, load_q, stream_q, enable_q, done_q;
  logic                 hs, last;

  // Handshake is gated by clear_i so an aborted cycle never consumes a vector.
  assign in_ready_o     = stream_q & mm_ready_i & ~clear_i;
  assign mm_valid_o     = stream_q & in_valid_i & ~clear_i;
  assign hs             = in_valid_i & in_ready_o;
  assign last           = (cnt_q == len_q - CNT_WIDTH'(1));

  // Clear has priority inside the tracker, so load is suppressed under an abort.
  assign mm_clear_o     = clear_q | clear_i;
  assign mm_load_en_o   = load_q & ~clear_i;
  assign mm_enable_o    = enable_q;
  assign mm_ready_o     = enable_q;
  assign mm_operation_o = mode_q;
  assign mm_strb_o      = in_strb_i;
  assign mm_vect_o      = in_vect_i;
  assign mm_load_o      = init_val_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q & ~clear_i;
  assign result_o       = result_q;

  // Next-state selection; an abort always returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = CLEAR;
      CLEAR: begin
        if (init_en_q)          state_d = LOAD;
        else if (len_q == '0)   state_d = DONE;
        else                    state_d = STREAM;
      end
      LOAD:    state_d = (len_q == '0) ? DONE : STREAM;
      STREAM:  if (hs && last) state_d = (NUM_REGS > 0) ? DRAIN : DONE;
      DRAIN:   if (drain_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // State register, registered state-decoded outputs, job latches and counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      clear_q    <= 1'b0;
      load_q     <= 1'b0;
      stream_q   <= 1'b0;
      enable_q   <= 1'b0;
      done_q     <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      drain_q    <= '0;
      mode_q     <= MODE_MAX;
      init_en_q  <= 1'b0;
      init_val_q <= '0;
      result_q   <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != IDLE);
      clear_q  <= (state_d == CLEAR);
      load_q   <= (state_d == LOAD);
      stream_q <= (state_d == STREAM);
      enable_q <= (state_d == STREAM) || (state_d == DRAIN);
      done_q   <= (state_d == DONE);
      if (clear_i) begin
        cnt_q   <= '0;
        drain_q <= '0;
      end else begin
        if (state_q == IDLE && start_i) begin
          len_q      <= len_i;
          mode_q     <= mode_i;
          init_en_q  <= init_en_i;
          init_val_q <= init_val_i;
        end
        if (state_q == CLEAR) cnt_q <= '0;
        else if (hs)          cnt_q <= cnt_q + CNT_WIDTH'(1);
        if (state_d == DRAIN && state_q != DRAIN)
          drain_q <= DRAIN_INIT;
        else if (state_q == DRAIN && drain_q != '0)
          drain_q <= drain_q - DW'(1);
        if (state_q == DONE) result_q <= mm_cur_minmax_i;
      end
    end
  end

endmodule

// File: tb/tb_sfm_minmax_ctrl.sv
// Bench for sfm_minmax_ctrl: three instances (NUM_REGS = 0, 1, 2), each with a
// behavioural tracker, driven by a job table, hand sequences and random jobs.
module tb_sfm_minmax_ctrl;

  localparam logic [15:0] NEG_INF = 16'hFF80;
  localparam logic [15:0] POS_INF = 16'h7F80;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic        clear_s [3], start_s [3], mode_s [3], init_en_s [3], in_valid_s [3], mm_ready_s [3];
  logic [15:0] len_s [3], init_val_s [3], vect_s [3];
  logic [0:0]  strb_s [3];
  logic        in_ready [3], mm_clear [3], mm_enable [3], mm_valid [3], mm_ready_o [3];
  logic        mm_load_en [3], mm_op [3], busy [3], done [3];
  logic [0:0]  mm_strb [3];
  logic [15:0] mm_vect [3], mm_load [3], result [3];

  logic [15:0] jv [$];
  logic        js [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Total order on non-NaN bfloat16 codes.
  function automatic logic [15:0] fkey(input logic [15:0] x);
    return x[15] ? ~x : (x | 16'h8000);
  endfunction

  function automatic logic [15:0] better(input logic md, input logic [15:0] a, input logic [15:0] b);
    if (md) return (fkey(b) > fkey(a)) ? b : a;
    return (fkey(b) < fkey(a)) ? b : a;
  endfunction

  function automatic logic [15:0] ref_mm(input logic md, input logic ie, input logic [15:0] iv);
    logic [15:0] acc;
    acc = ie ? iv : (md ? NEG_INF : POS_INF);
    foreach (jv[i]) if (js[i]) acc = better(md, acc, jv[i]);
    return acc;
  endfunction

  function automatic logic [15:0] rnd_val();
    logic [15:0] v;
    v[15]   = 1'($urandom_range(0, 1));
    v[14:7] = 8'($urandom_range(0, 254));
    v[6:0]  = 7'($urandom_range(0, 127));
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    logic [15:0] cur;

    sfm_minmax_ctrl #(.WIDTH(16), .VECT_WIDTH(1), .NUM_REGS(g), .CNT_WIDTH(16)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_s[g]), .start_i(start_s[g]),
      .len_i(len_s[g]), .mode_i(mode_s[g]), .init_en_i(init_en_s[g]), .init_val_i(init_val_s[g]),
      .in_valid_i(in_valid_s[g]), .in_ready_o(in_ready[g]), .in_strb_i(strb_s[g]), .in_vect_i(vect_s[g]),
      .mm_clear_o(mm_clear[g]), .mm_enable_o(mm_enable[g]), .mm_valid_o(mm_valid[g]),
      .mm_ready_o(mm_ready_o[g]), .mm_load_en_o(mm_load_en[g]), .mm_operation_o(mm_op[g]),
      .mm_strb_o(mm_strb[g]), .mm_vect_o(mm_vect[g]), .mm_load_o(mm_load[g]),
      .mm_ready_i(mm_ready_s[g]), .mm_cur_minmax_i(cur),
      .busy_o(busy[g]), .done_o(done[g]), .result_o(result[g])
    );

    if (g == 0) begin : g_direct
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= '0;
        else if (mm_clear[g]) cur <= mm_op[g] ? NEG_INF : POS_INF;
        else if (mm_load_en[g]) cur <= mm_load[g];
        else if (mm_enable[g] && mm_valid[g] && mm_ready_s[g] && mm_strb[g][0])
          cur <= better(mm_op[g], cur, mm_vect[g]);
      end
    end else begin : g_piped
      logic [15:0] pd [1:g];
      logic        pv [1:g];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cur <= '0;
          for (int i = 1; i <= g; i++) begin pv[i] <= 1'b0; pd[i] <= '0; end
        end else if (mm_clear[g]) begin
          cur <= mm_op[g] ? NEG_INF : POS_INF;
          for (int i = 1; i <= g; i++) pv[i] <= 1'b0;
        end else begin
          if (mm_load_en[g]) cur <= mm_load[g];
          else if (pv[g]) cur <= better(mm_op[g], cur, pd[g]);
          if (mm_enable[g]) begin
            pv[1] <= mm_valid[g] & mm_ready_s[g] & mm_strb[g][0];
            pd[1] <= mm_vect[g];
            for (int i = 2; i <= g; i++) begin pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; end
          end
        end
      end
    end
  end

  // vmode: 0 valid always, 1 toggling, 2 random. stall: -1 none, -2 random, >=0 three-cycle gap.
  task automatic run_job(input int s, input logic md, input logic ie, input logic [15:0] iv,
                         input int len, input int vmode, input int stall,
                         output int t_start, output int t_last, output int t_done, output int n_hs,
                         output int t_clr, output int t_ld, output int n_ld,
                         output logic rdy_seen, output logic timed_out);
    int   idx;
    logic want, tog;
    idx = 0; tog = 1'b0;
    n_hs = 0; t_done = -1; t_clr = -1; t_ld = -1; n_ld = 0; rdy_seen = 1'b0; timed_out = 1'b1;
    @(negedge clk);
    start_s[s] = 1'b1; len_s[s] = 16'(len); mode_s[s] = md; init_en_s[s] = ie; init_val_s[s] = iv;
    t_start = cyc; t_last = cyc;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) begin
        @(negedge clk);
        start_s[s] = 1'b0;
      end
      tog = ~tog;
      case (vmode)
        0:       want = 1'b1;
        1:       want = tog;
        default: want = 1'($urandom_range(0, 1));
      endcase
      in_valid_s[s] = (idx < len) && want;
      vect_s[s]     = (idx < len) ? jv[idx] : 16'($urandom());
      strb_s[s]     = (idx < len) ? js[idx] : 1'b1;
      if (stall == -2) mm_ready_s[s] = ($urandom_range(0, 3) != 0);
      else             mm_ready_s[s] = !(stall >= 0 && c >= stall && c < stall + 3);
      #1;
      if (in_ready[s]) rdy_seen = 1'b1;
      if (mm_clear[s] && t_clr < 0) t_clr = cyc;
      if (mm_load_en[s]) begin n_ld++; t_ld = cyc; end
      if (in_valid_s[s] && in_ready[s]) begin idx++; n_hs++; t_last = cyc; end
      if (done[s]) begin t_done = cyc; timed_out = 1'b0; break; end
    end
    @(negedge clk);
    start_s[s] = 1'b0; in_valid_s[s] = 1'b0; mm_ready_s[s] = 1'b1;
  endtask

  typedef struct {
    int              nr;
    logic            md;
    logic            ie;
    logic [15:0]     iv;
    int              len;
    logic [3:0][15:0] v;
    int              vmode;
    int              stall;
    logic [15:0]     exp_res;
    int              exp_lat;
  } row_t;

  initial begin
    row_t        rows [7];
    int          t_start, t_last, t_done, n_hs, t_clr, t_ld, n_ld, idx, s, len, lat;
    logic        rdy_seen, timed_out, md, ie;
    logic [15:0] iv, prev, exp;

    rows[0] = '{nr:0, md:1'b1, ie:1'b0, iv:16'h0000, len:3, v:{16'h0000, 16'h4000, 16'h4040, 16'h3F80},
                vmode:0, stall:-1, exp_res:16'h4040, exp_lat:1};
    rows[1] = '{nr:2, md:1'b0, ie:1'b1, iv:16'hBF80, len:2, v:{16'h0000, 16'h0000, 16'h4000, 16'h3F80},
                vmode:0, stall:-1, exp_res:16'hBF80, exp_lat:3};
    rows[2] = '{nr:0, md:1'b1, ie:1'b0, iv:16'h0000, len:0, v:'0,
                vmode:0, stall:-1, exp_res:16'hFF80, exp_lat:2};
    rows[3] = '{nr:1, md:1'b1, ie:1'b0, iv:16'h0000, len:4, v:{16'h4000, 16'h40A0, 16'hC000, 16'h3F80},
                vmode:1, stall:4, exp_res:16'h40A0, exp_lat:2};
    rows[4] = '{nr:0, md:1'b0, ie:1'b1, iv:16'h4000, len:3, v:{16'h0000, 16'hBF00, 16'h3F00, 16'h4080},
                vmode:0, stall:-1, exp_res:16'hBF00, exp_lat:1};
    rows[5] = '{nr:2, md:1'b0, ie:1'b1, iv:16'h1234, len:0, v:'0,
                vmode:0, stall:-1, exp_res:16'h1234, exp_lat:3};
    rows[6] = '{nr:1, md:1'b1, ie:1'b1, iv:16'h4100, len:2, v:{16'h0000, 16'h0000, 16'hC000, 16'h3F80},
                vmode:1, stall:-1, exp_res:16'h4100, exp_lat:2};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clear_s[i] = 1'b0; start_s[i] = 1'b0; mode_s[i] = 1'b0; init_en_s[i] = 1'b0;
      in_valid_s[i] = 1'b1; mm_ready_s[i] = 1'b1; len_s[i] = '0; init_val_s[i] = '0;
      vect_s[i] = 16'h4000; strb_s[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d_busy", i), busy[i], 0);
      chk($sformatf("rst%0d_done", i), done[i], 0);
      chk($sformatf("rst%0d_result", i), result[i], 0);
      chk($sformatf("rst%0d_mode", i), mm_op[i], 1);
      chk($sformatf("rst%0d_ready", i), in_ready[i], 0);
      chk($sformatf("rst%0d_strobes", i),
          {mm_clear[i], mm_enable[i], mm_valid[i], mm_ready_o[i], mm_load_en[i]}, 0);
    end
    for (int i = 0; i < 3; i++) in_valid_s[i] = 1'b0;

    for (int r = 0; r < 7; r++) begin
      jv.delete(); js.delete();
      for (int i = 0; i < rows[r].len; i++) begin jv.push_back(rows[r].v[i]); js.push_back(1'b1); end
      run_job(rows[r].nr, rows[r].md, rows[r].ie, rows[r].iv, rows[r].len, rows[r].vmode, rows[r].stall,
              t_start, t_last, t_done, n_hs, t_clr, t_ld, n_ld, rdy_seen, timed_out);
      #1;
      lat = (rows[r].len > 0) ? (t_done - t_last) : (t_done - t_start);
      chk($sformatf("row%0d_timeout", r), timed_out, 0);
      chk($sformatf("row%0d_result", r), result[rows[r].nr], rows[r].exp_res);
      chk($sformatf("row%0d_latency", r), lat, rows[r].exp_lat);
      chk($sformatf("row%0d_handshakes", r), n_hs, rows[r].len);
      chk($sformatf("row%0d_ready_seen", r), rdy_seen, rows[r].len > 0);
      chk($sformatf("row%0d_clear_cycle", r), t_clr - t_start, 1);
      chk($sformatf("row%0d_loads", r), n_ld, rows[r].ie);
      if (rows[r].ie) chk($sformatf("row%0d_load_after_clear", r), t_ld - t_clr, 1);
      chk($sformatf("row%0d_idle", r), busy[rows[r].nr], 0);
    end

    // Abort in STREAM after two of five vectors, then a fresh job.
    s = 1; prev = result[s];
    jv.delete();
    for (int i = 0; i < 5; i++) jv.push_back(16'h4400 + 16'(i * 16'h0080));
    @(negedge clk);
    start_s[s] = 1'b1; len_s[s] = 16'd5; mode_s[s] = 1'b1; init_en_s[s] = 1'b0;
    idx = 0;
    for (int c = 0; c < 50 && idx < 2; c++) begin
      if (c > 0) begin @(negedge clk); start_s[s] = 1'b0; end
      in_valid_s[s] = 1'b1; vect_s[s] = jv[idx];
      #1;
      if (in_ready[s]) idx++;
    end
    chk("abort_prefix_handshakes", idx, 2);
    @(negedge clk);
    clear_s[s] = 1'b1; in_valid_s[s] = 1'b1; vect_s[s] = jv[2];
    #1;
    chk("abort_mm_clear", mm_clear[s], 1);
    chk("abort_done", done[s], 0);
    @(negedge clk);
    clear_s[s] = 1'b0; in_valid_s[s] = 1'b0;
    #1;
    chk("abort_idle", busy[s], 0);
    chk("abort_no_ready", in_ready[s], 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("abort_no_done", done[s], 0);
    end
    chk("abort_result_kept", result[s], prev);
    jv.delete(); js.delete(); jv.push_back(16'h3F80); js.push_back(1'b1);
    run_job(s, 1'b1, 1'b0, 16'h0, 1, 0, -1, t_start, t_last, t_done, n_hs, t_clr, t_ld, n_ld, rdy_seen, timed_out);
    #1;
    chk("after_abort_timeout", timed_out, 0);
    chk("after_abort_result", result[s], 16'h3F80);

    // Start pulses during STREAM are ignored; reset arrives in DRAIN.
    s = 2;
    jv.delete(); jv.push_back(16'h4000); jv.push_back(16'h4040);
    @(negedge clk);
    start_s[s] = 1'b1; len_s[s] = 16'd2; mode_s[s] = 1'b0; init_en_s[s] = 1'b1; init_val_s[s] = 16'h3C00;
    idx = 0;
    for (int c = 0; c < 50 && idx < 2; c++) begin
      if (c > 0) begin
        @(negedge clk);
        start_s[s] = (c >= 3); len_s[s] = 16'd7;
      end
      mm_ready_s[s] = (c != 3);
      in_valid_s[s] = 1'b1; vect_s[s] = jv[idx];
      #1;
      if (in_ready[s]) idx++;
    end
    @(negedge clk);
    start_s[s] = 1'b0; in_valid_s[s] = 1'b0; mm_ready_s[s] = 1'b1;
    #1;
    chk("drain_handshakes", idx, 2);
    chk("drain_busy", busy[s], 1);
    chk("drain_no_ready", in_ready[s], 0);
    chk("drain_enable", mm_enable[s], 1);
    chk("drain_no_done", done[s], 0);
    rst_n = 1'b0;
    #1;
    chk("rst_drain_busy", busy[s], 0);
    chk("rst_drain_done", done[s], 0);
    chk("rst_drain_result", result[s], 0);
    chk("rst_drain_mode", mm_op[s], 1);
    chk("rst_drain_load_val", mm_load[s], 0);
    chk("rst_drain_ready", in_ready[s], 0);
    chk("rst_drain_strobes", {mm_clear[s], mm_enable[s], mm_valid[s], mm_ready_o[s], mm_load_en[s]}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_busy", busy[s], 0);
    chk("post_rst_done", done[s], 0);

    // Random jobs against the reference fold.
    for (int j = 0; j < 40; j++) begin
      s   = $urandom_range(0, 2);
      md  = 1'($urandom_range(0, 1));
      ie  = ($urandom_range(0, 3) == 0);
      iv  = rnd_val();
      len = $urandom_range(0, 8);
      jv.delete(); js.delete();
      for (int i = 0; i < len; i++) begin
        jv.push_back(rnd_val());
        js.push_back($urandom_range(0, 4) != 0);
      end
      exp = ref_mm(md, ie, iv);
      run_job(s, md, ie, iv, len, 2, -2, t_start, t_last, t_done, n_hs, t_clr, t_ld, n_ld, rdy_seen, timed_out);
      #1;
      lat = (len > 0) ? (t_done - t_last) : (t_done - t_start);
      chk($sformatf("rnd%0d_timeout", j), timed_out, 0);
      chk($sformatf("rnd%0d_result", j), result[s], exp);
      chk($sformatf("rnd%0d_handshakes", j), n_hs, len);
      chk($sformatf("rnd%0d_latency", j), lat, (len > 0) ? s + 1 : (ie ? 3 : 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
